axi_lite_master: RTL and testbench

- AXI4-Lite initiator bridge between a simple core-side request/response port (IFU/LSU side) and the io_master AXI channel group that feeds axi_slave.
- Converts one request at a time into AR/R or AW/W/B transactions and returns the read data and response status.
- Single outstanding transaction; no bursts, no IDs.

---
 rtl/axi_lite_master.sv | 150 +++++++++++++++
 tb/tb_axi_lite_master.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns one core request at a time into an AR/R or AW/W/B
// exchange and returns read data plus an error flag on a registered response port.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a core request
// RD_ADDR | arvalid high, waiting for arready
// RD_DATA | rready high, waiting for rvalid
// WR_REQ  | awvalid/wvalid high until their own handshakes complete
// WR_RESP | bready high, waiting for bvalid
// RESP    | resp_valid high, waiting for resp_ready
module axi_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  io_master_awvalid,
    input  logic                  io_master_awready,
    output logic [ADDR_W-1:0]     io_master_awaddr,
    output logic                  io_master_wvalid,
    input  logic                  io_master_wready,
    output logic [DATA_W-1:0]     io_master_wdata,
    output logic [DATA_W/8-1:0]   io_master_wstrb,
    input  logic                  io_master_bvalid,
    output logic                  io_master_bready,
    input  logic [1:0]            io_master_bresp,
    output logic                  io_master_arvalid,
    input  logic                  io_master_arready,
    output logic [ADDR_W-1:0]     io_master_araddr,
    input  logic                  io_master_rvalid,
    output logic                  io_master_rready,
    input  logic [DATA_W-1:0]     io_master_rdata,
    input  logic [1:0]            io_master_rresp
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_hs;
    logic   w_hs;

    assign aw_hs = io_master_awvalid && io_master_awready;
    assign w_hs  = io_master_wvalid && io_master_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            aw_done           <= 1'b0;
            w_done            <= 1'b0;
            req_ready         <= 1'b0;
            resp_valid        <= 1'b0;
            resp_rdata        <= '0;
            resp_err          <= 1'b0;
            io_master_awvalid <= 1'b0;
            io_master_awaddr  <= '0;
            io_master_wvalid  <= 1'b0;
            io_master_wdata   <= '0;
            io_master_wstrb   <= '0;
            io_master_bready  <= 1'b0;
            io_master_arvalid <= 1'b0;
            io_master_araddr  <= '0;
            io_master_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (req_we) begin
                            io_master_awaddr  <= req_addr;
                            io_master_wdata   <= req_wdata;
                            io_master_wstrb   <= req_wstrb;
                            io_master_awvalid <= 1'b1;
                            io_master_wvalid  <= 1'b1;
                            aw_done           <= 1'b0;
                            w_done            <= 1'b0;
                            state             <= WR_REQ;
                        end else begin
                            io_master_araddr  <= req_addr;
                            io_master_arvalid <= 1'b1;
                            state             <= RD_ADDR;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (io_master_arready) begin
                        io_master_arvalid <= 1'b0;
                        io_master_rready  <= 1'b1;
                        state             <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (io_master_rvalid) begin
                        resp_rdata       <= io_master_rdata;
                        resp_err         <= io_master_rresp[1];
                        io_master_rready <= 1'b0;
                        resp_valid       <= 1'b1;
                        state            <= RESP;
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently; either may finish first or both together
                    if (aw_hs) begin
                        io_master_awvalid <= 1'b0;
                        aw_done           <= 1'b1;
                    end
                    if (w_hs) begin
                        io_master_wvalid <= 1'b0;
                        w_done           <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        io_master_bready <= 1'b1;
                        state            <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (io_master_bvalid) begin
                        resp_rdata       <= '0;
                        resp_err         <= io_master_bresp[1];
                        io_master_bready <= 1'b0;
                        resp_valid       <= 1'b1;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed and randomized checks of axi_lite_master against a word-memory slave
// with programmable channel delays and an abstract request-level reference memory.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        io_master_awvalid, io_master_awready;
    logic [31:0] io_master_awaddr;
    logic        io_master_wvalid, io_master_wready;
    logic [31:0] io_master_wdata;
    logic [3:0]  io_master_wstrb;
    logic        io_master_bvalid, io_master_bready;
    logic [1:0]  io_master_bresp;
    logic        io_master_arvalid, io_master_arready;
    logic [31:0] io_master_araddr;
    logic        io_master_rvalid, io_master_rready;
    logic [31:0] io_master_rdata;
    logic [1:0]  io_master_rresp;

    always #5 clk = ~clk;

    axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
        .io_master_awaddr(io_master_awaddr),
        .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
        .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
        .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready),
        .io_master_bresp(io_master_bresp),
        .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
        .io_master_araddr(io_master_araddr),
        .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
        .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp)
    );

    // Slave response code is a pure function of the address: bits [5:4]
    function automatic logic [1:0] resp_code(input logic [31:0] a);
        return a[5:4];
    endfunction

    function automatic logic [31:0] init_word(input int idx);
        logic [31:0] a;
        a = 32'h8000_0000 | (idx << 2);
        return (idx == 0) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0F0F);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    logic r_pend, b_pend, aw_got, w_got;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] smem [16];
    logic        aw_now, w_now;
    logic [31:0] wr_a, wr_d;
    logic [3:0]  wr_s;

    assign aw_now = io_master_awvalid && io_master_awready;
    assign w_now  = io_master_wvalid && io_master_wready;
    assign wr_a   = aw_now ? io_master_awaddr : s_awaddr;
    assign wr_d   = w_now ? io_master_wdata : s_wdata;
    assign wr_s   = w_now ? io_master_wstrb : s_wstrb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            io_master_arready <= 1'b0; io_master_awready <= 1'b0; io_master_wready <= 1'b0;
            io_master_rvalid <= 1'b0; io_master_bvalid <= 1'b0;
            io_master_rdata <= '0; io_master_rresp <= '0; io_master_bresp <= '0;
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
            for (int i = 0; i < 16; i++) smem[i] <= init_word(i);
        end else begin
            if (io_master_arvalid && io_master_arready) begin
                ar_cnt <= 0;
                io_master_arready <= (ar_delay == 0);
                io_master_rdata <= smem[io_master_araddr[5:2]];
                io_master_rresp <= resp_code(io_master_araddr);
                if (r_delay == 0) io_master_rvalid <= 1'b1;
                else begin r_pend <= 1'b1; r_cnt <= 1; end
            end else if (io_master_arvalid) begin
                ar_cnt <= ar_cnt + 1;
                io_master_arready <= (ar_cnt + 1 >= ar_delay);
            end else io_master_arready <= (ar_delay == 0);

            if (io_master_rvalid && io_master_rready) io_master_rvalid <= 1'b0;
            else if (r_pend) begin
                if (r_cnt >= r_delay) begin io_master_rvalid <= 1'b1; r_pend <= 1'b0; end
                else r_cnt <= r_cnt + 1;
            end

            if (aw_now) begin aw_cnt <= 0; io_master_awready <= (aw_delay == 0); end
            else if (io_master_awvalid) begin
                aw_cnt <= aw_cnt + 1;
                io_master_awready <= (aw_cnt + 1 >= aw_delay);
            end else io_master_awready <= (aw_delay == 0);

            if (w_now) begin w_cnt <= 0; io_master_wready <= (w_delay == 0); end
            else if (io_master_wvalid) begin
                w_cnt <= w_cnt + 1;
                io_master_wready <= (w_cnt + 1 >= w_delay);
            end else io_master_wready <= (w_delay == 0);

            if ((aw_got || aw_now) && (w_got || w_now)) begin
                smem[wr_a[5:2]] <= merge(smem[wr_a[5:2]], wr_d, wr_s);
                io_master_bresp <= resp_code(wr_a);
                aw_got <= 1'b0; w_got <= 1'b0;
                if (b_delay == 0) io_master_bvalid <= 1'b1;
                else begin b_pend <= 1'b1; b_cnt <= 1; end
            end else begin
                if (aw_now) begin aw_got <= 1'b1; s_awaddr <= io_master_awaddr; end
                if (w_now) begin w_got <= 1'b1; s_wdata <= io_master_wdata; s_wstrb <= io_master_wstrb; end
            end

            if (io_master_bvalid && io_master_bready) io_master_bvalid <= 1'b0;
            else if (b_pend) begin
                if (b_cnt >= b_delay) begin io_master_bvalid <= 1'b1; b_pend <= 1'b0; end
                else b_cnt <= b_cnt + 1;
            end
        end
    end

    // Handshake-stability monitor and handshake counters
    int prot_err = 0, ar_hs_cnt = 0, aw_hs_cnt = 0;
    logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_rv, p_rr, p_rerr;
    logic [31:0] p_araddr, p_awaddr, p_wdata, p_rdata;
    logic [3:0]  p_wstrb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p_arv <= 1'b0; p_arr <= 1'b0; p_awv <= 1'b0; p_awr <= 1'b0;
            p_wv <= 1'b0; p_wr <= 1'b0; p_rv <= 1'b0; p_rr <= 1'b0;
        end else begin
            if (p_arv && !p_arr && (!io_master_arvalid || io_master_araddr != p_araddr)) prot_err <= prot_err + 1;
            if (p_awv && !p_awr && (!io_master_awvalid || io_master_awaddr != p_awaddr)) prot_err <= prot_err + 1;
            if (p_wv && !p_wr && (!io_master_wvalid || io_master_wdata != p_wdata || io_master_wstrb != p_wstrb)) prot_err <= prot_err + 1;
            if (p_rv && !p_rr && (!resp_valid || resp_rdata != p_rdata || resp_err != p_rerr)) prot_err <= prot_err + 1;
            if (io_master_arvalid && io_master_arready) ar_hs_cnt <= ar_hs_cnt + 1;
            if (io_master_awvalid && io_master_awready) aw_hs_cnt <= aw_hs_cnt + 1;
            p_arv <= io_master_arvalid; p_arr <= io_master_arready; p_araddr <= io_master_araddr;
            p_awv <= io_master_awvalid; p_awr <= io_master_awready; p_awaddr <= io_master_awaddr;
            p_wv <= io_master_wvalid; p_wr <= io_master_wready;
            p_wdata <= io_master_wdata; p_wstrb <= io_master_wstrb;
            p_rv <= resp_valid; p_rr <= resp_ready; p_rdata <= resp_rdata; p_rerr <= resp_err;
        end
    end

    // Reference: request-level memory and expected response
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        pend_we;
    logic [3:0]  pend_idx;
    logic [31:0] pend_d;
    logic [3:0]  pend_s;
    int n_pass = 0, n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        pend_we = 1'b0;
    endtask

    task automatic expect_txn(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_rdata = we ? 32'h0 : ref_mem[a[5:2]];
        exp_err   = resp_code(a) >= 2'b10;
        pend_we   = we;
        pend_idx  = a[5:2];
        pend_d    = d;
        pend_s    = s;
    endtask

    // Returns in the cycle after acceptance
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        req_we = we; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
        while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("accept_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        expect_txn(we, a, d, s);
    endtask

    // lat = cycles from the accepting cycle to the first resp_valid cycle
    task automatic wait_resp(output int lat);
        lat = 1;
        do begin @(posedge clk); #1; lat++; end while (!resp_valid && lat < 300);
        check("resp_timeout", resp_valid, 1'b1);
    endtask

    task automatic check_resp(input string tag);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, resp_err, exp_err);
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_clear", resp_valid, 1'b0);
        check("ready_after_resp", req_ready, 1'b1);
        if (pend_we) ref_mem[pend_idx] = merge(ref_mem[pend_idx], pend_d, pend_s);
        pend_we = 1'b0;
    endtask

    task automatic set_delays(input int ar, input int r, input int aw, input int w, input int b);
        ar_delay = ar; r_delay = r; aw_delay = aw; w_delay = w; b_delay = b;
    endtask

    initial begin
        int lat, ar0, aw0;
        logic we;
        logic [31:0] a;
        logic [3:0]  s;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        resp_ready = 1'b0;
        ref_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_arvalid", io_master_arvalid, 1'b0);
        check("rst_awvalid", io_master_awvalid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_req_ready", req_ready, 1'b1);

        // Minimum-latency read
        set_delays(0, 0, 0, 0, 0);
        ar0 = ar_hs_cnt;
        issue(1'b0, 32'h8000_0000, 32'h0, 4'h0);
        check("rd_arvalid", io_master_arvalid, 1'b1);
        check("rd_araddr", io_master_araddr, 32'h8000_0000);
        wait_resp(lat);
        check("rd_latency", lat, 3);
        check_resp("rd");
        check("rd_data_const", resp_rdata, 32'hDEAD_BEEF);
        check("rd_one_ar", ar_hs_cnt - ar0, 1);
        finish_resp();

        // Write with W accepted two cycles before AW
        set_delays(0, 0, 2, 0, 0);
        issue(1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF);
        check("wr_c1_aw", io_master_awvalid, 1'b1);
        check("wr_c1_w", io_master_wvalid, 1'b1);
        @(posedge clk); #1;
        check("wr_c2_w", io_master_wvalid, 1'b0);
        check("wr_c2_aw", io_master_awvalid, 1'b1);
        check("wr_c2_b", io_master_bready, 1'b0);
        @(posedge clk); #1;
        check("wr_c3_aw", io_master_awvalid, 1'b1);
        check("wr_c3_b", io_master_bready, 1'b0);
        @(posedge clk); #1;
        check("wr_c4_aw", io_master_awvalid, 1'b0);
        check("wr_c4_b", io_master_bready, 1'b1);
        wait_resp(lat);
        check_resp("wr_skew");
        finish_resp();
        set_delays(0, 0, 0, 0, 0);
        issue(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        wait_resp(lat);
        check_resp("wr_readback");
        check("wr_readback_val", resp_rdata, 32'h1234_5678);
        finish_resp();

        // Error responses: SLVERR read, DECERR write
        issue(1'b0, 32'h8000_0020, 32'h0, 4'h0);
        wait_resp(lat);
        check_resp("rd_slverr");
        check("rd_slverr_flag", resp_err, 1'b1);
        finish_resp();
        issue(1'b1, 32'h8000_0030, 32'hCAFE_F00D, 4'h3);
        wait_resp(lat);
        check("wr_min_latency", lat, 3);
        check_resp("wr_decerr");
        check("wr_decerr_flag", resp_err, 1'b1);
        finish_resp();

        // Response backpressure with a new request already waiting
        issue(1'b0, 32'h8000_0008, 32'h0, 4'h0);
        wait_resp(lat);
        check_resp("bp_first");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_000C;
        ar0 = ar_hs_cnt; aw0 = aw_hs_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_resp_valid", resp_valid, 1'b1);
            check("bp_rdata", resp_rdata, exp_rdata);
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_no_ar", io_master_arvalid, 1'b0);
        end
        check("bp_ar_count", ar_hs_cnt - ar0, 0);
        check("bp_aw_count", aw_hs_cnt - aw0, 0);
        finish_resp();
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_second_taken", req_ready, 1'b0);
        check("bp_second_ar", io_master_arvalid, 1'b1);
        check("bp_second_addr", io_master_araddr, 32'h8000_000C);
        expect_txn(1'b0, 32'h8000_000C, 32'h0, 4'h0);
        wait_resp(lat);
        check_resp("bp_second");
        finish_resp();

        // Stalled AR channel
        set_delays(10, 0, 0, 0, 0);
        issue(1'b0, 32'h8000_0014, 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            check("stall_arvalid", io_master_arvalid, 1'b1);
            check("stall_araddr", io_master_araddr, 32'h8000_0014);
            @(posedge clk); #1;
        end
        wait_resp(lat);
        check_resp("stall");
        finish_resp();

        // Asynchronous reset while AW/W are pending
        set_delays(0, 0, 5, 5, 0);
        issue(1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'hF);
        check("arst_pre_awvalid", io_master_awvalid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_awvalid", io_master_awvalid, 1'b0);
        check("arst_wvalid", io_master_wvalid, 1'b0);
        check("arst_awaddr", io_master_awaddr, 32'h0);
        check("arst_wdata", io_master_wdata, 32'h0);
        check("arst_wstrb", io_master_wstrb, 4'h0);
        check("arst_req_ready", req_ready, 1'b0);
        check("arst_bready", io_master_bready, 1'b0);
        set_delays(0, 0, 0, 0, 0);
        ref_reset();
        #4 rst = 1'b0;
        @(posedge clk); #1;
        check("arst_ready_after", req_ready, 1'b1);
        issue(1'b0, 32'h8000_0004, 32'h0, 4'h0);
        wait_resp(lat);
        check("arst_rd_latency", lat, 3);
        check_resp("arst_rd");
        finish_resp();

        // Randomized mix against the reference memory
        for (int t = 0; t < 40; t++) begin
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            a  = 32'h8000_0000 | ($urandom_range(0, 15) << 2);
            s  = 4'($urandom_range(0, 15));
            issue(we, a, $urandom, s);
            wait_resp(lat);
            if (ar_delay == 0 && r_delay == 0 && aw_delay == 0 && w_delay == 0 && b_delay == 0)
                check("rand_latency", lat, 3);
            check_resp("rand");
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            finish_resp();
        end

        check("protocol_stability", prot_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
